hcsr04_emulator: RTL and testbench

HCSR04_EMULATOR -- requirements
Module: hcsr04_emulator

---
 rtl/hcsr04_pkg.sv | 27 ++
 rtl/hcsr04_emulator_sync_2ff.sv | 22 ++
 rtl/hcsr04_emulator.sv | 151 +++++++++++++++
 tb/tb_hcsr04_emulator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 definitions: state enumeration and default timing at 50 MHz.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } hcsr04_state_e;

    localparam int unsigned DEF_TRIG_MIN   = 500;
    localparam int unsigned DEF_BURST_DLY  = 10000;
    localparam int unsigned DEF_CYC_PER_CM = 2900;
    localparam int unsigned DEF_MAX_CM     = 400;
    localparam int unsigned DEF_TIMEOUT    = 1900000;
    localparam int unsigned DEF_HOLDOFF    = 50000;

    localparam int unsigned DIST_W = 9;
    localparam int unsigned IGN_W  = 8;

    // Bits needed to hold values 0..maxval.
    function automatic int unsigned cnt_w(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/hcsr04_emulator_sync_2ff.sv
// Two-flop synchronizer for the asynchronous trigger input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: two back-to-back flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hcsr04_emulator.sv
// HC-SR04 ultrasonic sensor emulator: qualifies a trigger pulse, waits the
// burst delay, then returns an echo whose width encodes distance_cm.
// Optional macro HCSR04_TIMEOUT_EN: out-of-range distances return a TIMEOUT
// wide echo instead of no echo.
module hcsr04_emulator
    import hcsr04_pkg::*;
#(
    parameter int unsigned TRIG_MIN   = DEF_TRIG_MIN,
    parameter int unsigned BURST_DLY  = DEF_BURST_DLY,
    parameter int unsigned CYC_PER_CM = DEF_CYC_PER_CM,
    parameter int unsigned MAX_CM     = DEF_MAX_CM,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned HOLDOFF    = DEF_HOLDOFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              echo,
    output logic              busy,
    output logic [IGN_W-1:0]  ignored_cnt
);

    localparam int unsigned TW_W   = cnt_w(TRIG_MIN);
    localparam int unsigned PH_MAX = (BURST_DLY > HOLDOFF) ? BURST_DLY : HOLDOFF;
    localparam int unsigned PH_W   = cnt_w(PH_MAX);
    localparam int unsigned SUB_MX = (TIMEOUT > CYC_PER_CM) ? TIMEOUT : CYC_PER_CM;
    localparam int unsigned SUB_W  = cnt_w(SUB_MX);

    hcsr04_state_e     state;
    logic              trig_s;
    logic              trig_s_d;
    logic [TW_W-1:0]   width_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] latched_cm;
    logic              lat_valid;
    logic              tmo;
    logic              sub_last;
    logic              cm_last;
    logic              trig_ok;
    logic              measuring;
    logic              ign_inc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (trigger),
        .q   (trig_s)
    );

    assign lat_valid = (latched_cm != '0) && (latched_cm <= DIST_W'(MAX_CM));
`ifdef HCSR04_TIMEOUT_EN
    assign tmo = ~lat_valid;
`else
    assign tmo = 1'b0;
`endif
    assign sub_last  = (sub_cnt == (tmo ? SUB_W'(TIMEOUT - 1) : SUB_W'(CYC_PER_CM - 1)));
    assign cm_last   = tmo || (cm_cnt == DIST_W'(latched_cm - DIST_W'(1)));
    // Width counter saturates at TRIG_MIN, so reaching it means qualified.
    assign trig_ok   = (width_cnt == TW_W'(TRIG_MIN));
    assign measuring = (state == ST_BURST) || (state == ST_ECHO) || (state == ST_HOLDOFF);
    assign ign_inc   = ((state == ST_TRIG_HI) && !trig_s && !trig_ok) ||
                       (measuring && trig_s && !trig_s_d);

    // Measurement sequencer with registered echo/busy and reject counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            trig_s_d    <= 1'b0;
            width_cnt   <= '0;
            ph_cnt      <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
            latched_cm  <= '0;
            echo        <= 1'b0;
            busy        <= 1'b0;
            ignored_cnt <= '0;
        end else begin
            trig_s_d <= trig_s;
            if (ign_inc && (ignored_cnt != '1)) begin
                ignored_cnt <= ignored_cnt + IGN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (trig_s) begin
                        state     <= ST_TRIG_HI;
                        width_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_TRIG_HI: begin
                    if (trig_s) begin
                        if (!trig_ok) width_cnt <= width_cnt + TW_W'(1);
                    end else if (trig_ok) begin
                        latched_cm <= distance_cm;
                        ph_cnt     <= '0;
                        state      <= ST_BURST;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (ph_cnt == PH_W'(BURST_DLY - 1)) begin
                        ph_cnt  <= '0;
                        sub_cnt <= '0;
                        cm_cnt  <= '0;
                        if (lat_valid || tmo) begin
                            state <= ST_ECHO;
                            echo  <= 1'b1;
                        end else begin
                            state <= ST_HOLDOFF;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_ECHO: begin
                    if (sub_last) begin
                        sub_cnt <= '0;
                        if (cm_last) begin
                            echo   <= 1'b0;
                            ph_cnt <= '0;
                            state  <= ST_HOLDOFF;
                        end else begin
                            cm_cnt <= cm_cnt + DIST_W'(1);
                        end
                    end else begin
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (ph_cnt == PH_W'(HOLDOFF - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    echo  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Bench for hcsr04_emulator with shortened timing parameters.
module tb_hcsr04_emulator;

    localparam int unsigned P_TRIG_MIN = 6;
    localparam int unsigned P_BD       = 12;
    localparam int unsigned P_CPC      = 3;
    localparam int unsigned P_MAX      = 20;
    localparam int unsigned P_TMO      = 100;
    localparam int unsigned P_HO       = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distance_cm = '0;
    logic       echo;
    logic       busy;
    logic [7:0] ignored_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hcsr04_emulator #(
        .TRIG_MIN   (P_TRIG_MIN),
        .BURST_DLY  (P_BD),
        .CYC_PER_CM (P_CPC),
        .MAX_CM     (P_MAX),
        .TIMEOUT    (P_TMO),
        .HOLDOFF    (P_HO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .ignored_cnt (ignored_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline of the current measurement as absolute cycle numbers.
    longint m_n = 0;
    longint rise_t = 0, fall_t = 0, end_t = 0;
    bit     sh0 = 0, sh1 = 0, ts_prev = 0, in_pulse = 0, active = 0;
    int     hi = 0;
    int     m_ign = 0;
    bit     m_echo = 0, m_busy = 0;

    task automatic model_step();
        bit ts;
        int w;
        int d;
        m_n++;
        if (rst) begin
            sh0 = 0; sh1 = 0; ts_prev = 0; in_pulse = 0; active = 0; m_ign = 0;
        end else begin
            ts  = sh1;
            sh1 = sh0;
            sh0 = trigger;
            if (active) begin
                if (ts && !ts_prev && m_ign < 255) m_ign++;
                if (m_n == end_t) active = 0;
            end else if (in_pulse) begin
                if (ts) hi++;
                else begin
                    in_pulse = 0;
                    if (hi >= int'(P_TRIG_MIN)) begin
                        d = int'(distance_cm);
                        if (d >= 1 && d <= int'(P_MAX)) w = d * int'(P_CPC);
`ifdef HCSR04_TIMEOUT_EN
                        else w = int'(P_TMO);
`else
                        else w = 0;
`endif
                        rise_t = m_n + P_BD;
                        fall_t = rise_t + w;
                        end_t  = fall_t + P_HO;
                        active = 1;
                    end else if (m_ign < 255) m_ign++;
                end
            end else if (ts) begin
                in_pulse = 1;
                hi = 0;
            end
            ts_prev = ts;
        end
        m_busy = in_pulse || active;
        m_echo = active && (m_n >= rise_t) && (m_n < fall_t);
    endtask

    // Cycle-by-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("echo", 32'(echo), 32'(m_echo));
            check("busy", 32'(busy), 32'(m_busy));
            check("ignored_cnt", 32'(ignored_cnt), 32'(m_ign));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int w, input int d);
        @(negedge clk);
        distance_cm = 9'(d);
        trigger = 1'b1;
        repeat (w) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_level(input string name, input bit sel_busy, input logic lvl,
                              input int budget, output int cnt, output bit saw_echo);
        cnt = 0;
        saw_echo = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (echo === 1'b1) saw_echo = 1;
            if ((sel_busy ? busy : echo) === lvl) break;
            if (cnt >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: no transition within %0d cycles", name, budget);
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    int  c;
    bit  seen;
    int  ign0;
    int  r;
    int  d;

    initial begin
        cyc(3);
        check("rst_echo", 32'(echo), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ign", 32'(ignored_cnt), 0);
        rst = 1'b0;
        cyc(2);

        // Nominal 10 cm measurement.
        pulse(10, 10);
        wait_level("nom_rise", 0, 1'b1, 200, c, seen);
        check("nom_rise_dly", 32'(c), 32'(P_BD + 3));
        wait_level("nom_fall", 0, 1'b0, 200, c, seen);
        check("nom_width", 32'(c), 32'(10 * P_CPC));
        wait_level("nom_idle", 1, 1'b0, 200, c, seen);
        check("nom_holdoff", 32'(c), 32'(P_HO));

        // Too-short trigger is rejected.
        pulse(3, 5);
        wait_level("short_idle", 1, 1'b0, 3, c, seen);
        check("short_busy_lat", 32'(c), 3);
        check("short_ign", 32'(ignored_cnt), 1);

        // Out-of-range distance.
        pulse(10, 450);
`ifdef HCSR04_TIMEOUT_EN
        wait_level("oor_rise", 0, 1'b1, 200, c, seen);
        check("oor_rise_dly", 32'(c), 32'(P_BD + 3));
        wait_level("oor_fall", 0, 1'b0, 400, c, seen);
        check("oor_width", 32'(c), 32'(P_TMO));
        wait_level("oor_idle", 1, 1'b0, 200, c, seen);
`else
        wait_level("oor_idle", 1, 1'b0, 400, c, seen);
        check("oor_busy_span", 32'(c), 32'(3 + P_BD + P_HO));
        check("oor_no_echo", 32'(seen), 0);
`endif

        // Second valid trigger during echo.
        pulse(10, 10);
        wait_level("dbl_rise", 0, 1'b1, 200, c, seen);
        ign0 = int'(ignored_cnt);
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            if (c == 2) begin trigger = 1'b1; distance_cm = 9'd15; end
            if (c == 12) trigger = 1'b0;
            if (echo === 1'b0 || c > 200) break;
        end
        trigger = 1'b0;
        check("dbl_width", 32'(c), 32'(10 * P_CPC));
        wait_level("dbl_idle", 1, 1'b0, 200, c, seen);
        check("dbl_ign", 32'(ignored_cnt), 32'(ign0 + 1));

        // Distance change after latch.
        pulse(10, 10);
        cyc(5);
        distance_cm = 9'd200;
        wait_level("chg_rise", 0, 1'b1, 200, c, seen);
        check("chg_rise_dly", 32'(c), 32'(P_BD + 3 - 5));
        wait_level("chg_fall", 0, 1'b0, 200, c, seen);
        check("chg_width", 32'(c), 32'(10 * P_CPC));
        wait_level("chg_idle", 1, 1'b0, 200, c, seen);

        // Reset mid-echo, then a 1 cm measurement.
        pulse(10, 10);
        wait_level("rm_rise", 0, 1'b1, 200, c, seen);
        cyc(4);
        rst = 1'b1;
        @(negedge clk);
        check("rm_echo", 32'(echo), 0);
        check("rm_busy", 32'(busy), 0);
        rst = 1'b0;
        cyc(2);
        pulse(10, 1);
        wait_level("one_rise", 0, 1'b1, 200, c, seen);
        wait_level("one_fall", 0, 1'b0, 200, c, seen);
        check("one_width", 32'(c), 32'(P_CPC));
        wait_level("one_idle", 1, 1'b0, 200, c, seen);

        // Trigger held high for a long time.
        @(negedge clk);
        distance_cm = 9'd4;
        trigger = 1'b1;
        cyc(100);
        check("hold_busy", 32'(busy), 1);
        check("hold_echo", 32'(echo), 0);
        trigger = 1'b0;
        wait_level("hold_rise", 0, 1'b1, 200, c, seen);
        check("hold_rise_dly", 32'(c), 32'(P_BD + 3));
        wait_level("hold_fall", 0, 1'b0, 200, c, seen);
        check("hold_width", 32'(c), 32'(4 * P_CPC));
        wait_level("hold_idle", 1, 1'b0, 200, c, seen);

        // Reject counter saturation.
        for (int i = 0; i < 260; i++) begin
            pulse(2, 5);
            cyc(3);
        end
        check("ign_sat", 32'(ignored_cnt), 255);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0:       d = 0;
                1:       d = 450;
                2:       d = int'(P_MAX);
                3:       d = int'(P_MAX) + 1;
                default: d = int'($urandom_range(1, P_MAX));
            endcase
            pulse(int'($urandom_range(1, 14)), d);
            for (int g = int'($urandom_range(0, 60)); g > 0; g--) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) distance_cm = 9'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                trigger = 1'($urandom_range(0, 1));
                cyc(2);
                rst = 1'b0;
                trigger = 1'b0;
            end
        end
        trigger = 1'b0;
        cyc(int'(P_BD + P_TMO + P_HO) + 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
